// File: rtl/inst_buffer_pkg.sv
// Shared constants and types for the instruction fetch buffer and the PC register.
package inst_buffer_pkg;

    localparam int unsigned IB_DEPTH   = 8;
    localparam int unsigned IB_ENTRY_W = 65;

    localparam logic Flush      = 1'b1;
    localparam logic ReadEnable = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
    } ib_entry_t;

endpackage

// File: rtl/ib_storage.sv
// Entry array: one synchronous write port, one asynchronous read port, no reset.
module ib_storage
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IB_DEPTH,
    parameter int unsigned W     = IB_ENTRY_W
) (
    input  logic                     aclk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_buffer.sv
// In-order fetch buffer between the icache response path and decode, with
// almost-full backpressure to the PC register and a sticky overflow flag.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = IB_DEPTH
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    input  logic        if_pred_taken,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_pred_taken,
    output logic        ibuffer_full,
    output logic        overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_HIGH = (AW+1)'(DEPTH - 1);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic          flushing;
    logic          push;
    logic          pop;
    logic          drop;
    ib_entry_t     wr_entry;
    ib_entry_t     head;

    assign flushing = (flush == Flush);
    assign id_valid = (count != '0);
    assign pop      = id_valid && (id_ready == ReadEnable) && !flushing;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign push     = if_valid && !flushing && ((count < CNT_MAX) || pop);
    assign drop     = if_valid && !flushing && (count == CNT_MAX) && !pop;

    assign wr_entry = '{pc: if_pc, inst: if_inst, pred_taken: if_pred_taken};

    ib_storage #(
        .DEPTH (DEPTH),
        .W     (IB_ENTRY_W)
    ) u_storage (
        .aclk  (aclk),
        .we    (push),
        .waddr (wp),
        .wdata (wr_entry),
        .raddr (rp),
        .rdata (head)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flushing) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        id_pc         = '0;
        id_inst       = '0;
        id_pred_taken = 1'b0;
        if (id_valid) begin
            id_pc         = head.pc;
            id_inst       = head.inst;
            id_pred_taken = head.pred_taken;
        end
    end

    assign ibuffer_full = (count >= CNT_HIGH);

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: fill, overflow, full push+pop, streaming wrap,
// flush and mid-stream reset. Instruction word is ~pc, predicted flag is pc[2].
module tb_inst_buffer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_pred_taken;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred_taken;
    logic        ibuffer_full;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    inst_buffer #(.DEPTH(8)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .flush         (flush),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_pred_taken (if_pred_taken),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_pred_taken (id_pred_taken),
        .ibuffer_full  (ibuffer_full),
        .overflow      (overflow)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        if_valid      = v;
        if_pc         = pc;
        if_inst       = ~pc;
        if_pred_taken = pc[2];
        id_ready      = rdy;
        flush         = fl;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(id_valid), 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_inst"}, id_inst, ~pc);
        chk({tag, "_pt"}, 32'(id_pred_taken), 32'(pc[2]));
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_pc"}, id_pc, 32'd0);
        chk({tag, "_inst"}, id_inst, 32'd0);
        chk({tag, "_pt"}, 32'(id_pred_taken), 32'd0);
        chk({tag, "_full"}, 32'(ibuffer_full), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_pc [8];

        aresetn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        aresetn = 1'b1;
        chk_empty("reset");
        chk("reset_ovf", 32'(overflow), 32'd0);

        // Three pushes, decode stalled
        drive(1'b1, 32'h1C00_0000, 1'b0, 1'b0);
        tick();
        chk_head("first_push", 32'h1C00_0000);
        drive(1'b1, 32'h1C00_0004, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h1C00_0008, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("three_count", 32'(dut.count), 32'd3);
        chk_head("three_head", 32'h1C00_0000);
        chk("three_full", 32'(ibuffer_full), 32'd0);

        // Fill to 7 -> almost full
        for (int unsigned i = 3; i < 7; i++) begin
            drive(1'b1, 32'h1C00_0000 + 32'(4 * i), 1'b0, 1'b0);
            tick();
            if (i == 5) chk("six_full", 32'(ibuffer_full), 32'd0);
        end
        chk("seven_full", 32'(ibuffer_full), 32'd1);
        chk("seven_count", 32'(dut.count), 32'd7);

        // 8th accepted, 9th dropped
        drive(1'b1, 32'h1C00_001C, 1'b0, 1'b0);
        tick();
        chk("eight_count", 32'(dut.count), 32'd8);
        chk("eight_ovf", 32'(overflow), 32'd0);
        drive(1'b1, 32'h1C00_0020, 1'b0, 1'b0);
        tick();
        chk("nine_ovf", 32'(overflow), 32'd1);
        chk("nine_count", 32'(dut.count), 32'd8);
        chk_head("nine_head", 32'h1C00_0000);

        // Full: push and pop together
        drive(1'b1, 32'h1C00_0100, 1'b1, 1'b0);
        tick();
        chk("fullpp_count", 32'(dut.count), 32'd8);
        exp_pc = '{32'h1C00_0004, 32'h1C00_0008, 32'h1C00_000C, 32'h1C00_0010,
                   32'h1C00_0014, 32'h1C00_0018, 32'h1C00_001C, 32'h1C00_0100};
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 8; i++) begin
            chk_head($sformatf("drain%0d", i), exp_pc[i]);
            tick();
            if (i == 0) chk("drain_full7", 32'(ibuffer_full), 32'd1);
            if (i == 1) chk("drain_full6", 32'(ibuffer_full), 32'd0);
        end
        chk_empty("drained");
        chk("drained_ovf", 32'(overflow), 32'd1);

        // Streaming push+pop across pointer wrap
        for (int unsigned i = 0; i < 20; i++) begin
            drive(1'b1, 32'h1C00_0200 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            chk_head($sformatf("stream%0d", i), 32'h1C00_0200 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk_empty("stream_end");

        // Flush with simultaneous push and pop
        for (int unsigned i = 0; i < 5; i++) begin
            drive(1'b1, 32'h1C00_0300 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        chk("pre_flush_count", 32'(dut.count), 32'd5);
        drive(1'b1, 32'h1C00_0400, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk_empty("flush");
        chk("flush_ovf", 32'(overflow), 32'd1);
        chk("flush_count", 32'(dut.count), 32'd0);
        drive(1'b1, 32'h1C00_0500, 1'b0, 1'b0);
        tick();
        chk_head("post_flush", 32'h1C00_0500);
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset mid-stream with 6 entries and overflow set
        for (int unsigned i = 1; i < 6; i++) begin
            drive(1'b1, 32'h1C00_0500 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(dut.count), 32'd6);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk_empty("midreset");
        chk("midreset_ovf", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
